// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: SRAM sequencer state encoding, shared with the top-level and array wrapper.
package sram_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ROW       = 2'b01,
        ACCESS    = 2'b10,
        PRECHARGE = 2'b11
    } state_t;
    localparam int MAX_ACCESS_CYCLES = 16;
endpackage

// File: rtl/sram_control_fsm.sv
// sram_control_fsm: sequences row/column/write/sense/precharge phases for one SRAM access per handshake.
module sram_control_fsm
    import sram_ctrl_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic read_not_write,
    output logic row_enable,
    output logic col_enable,
    output logic write_enable,
    output logic read_enable,
    output logic precharge_enable,
    output logic ready
);
    localparam int CW = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);
    state_t state, next_state;
    logic [CW-1:0] cnt;
    logic op_rd, next_op;
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:      next_state = enable ? ROW : IDLE;
            ROW:       next_state = ACCESS;
            ACCESS:    next_state = (cnt == LAST) ? PRECHARGE : ACCESS;
            PRECHARGE: next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        next_op = (state == IDLE && enable) ? read_not_write : op_rd;
    end
    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            op_rd            <= 1'b1;
            row_enable       <= 1'b0;
            col_enable       <= 1'b0;
            write_enable     <= 1'b0;
            read_enable      <= 1'b0;
            precharge_enable <= 1'b1;
            ready            <= 1'b1;
        end else begin
            state            <= next_state;
            cnt              <= (state == ACCESS) ? cnt + CW'(1) : '0;
            op_rd            <= next_op;
            row_enable       <= (next_state == ROW) || (next_state == ACCESS);
            col_enable       <= next_state == ACCESS;
            write_enable     <= (next_state == ACCESS) && !next_op;
            read_enable      <= (next_state == ACCESS) && next_op;
            precharge_enable <= (next_state == IDLE) || (next_state == PRECHARGE);
            ready            <= next_state == IDLE;
        end
    end
endmodule

// File: tb/tb_sram_control_fsm.sv
// tb_sram_control_fsm: directed checks of the SRAM sequencer for ACCESS_CYCLES=1 and 4.
module tb_sram_control_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en1 = 1'b0, rnw1 = 1'b1, en4 = 1'b0, rnw4 = 1'b1;
    logic row1, col1, wr1, rd1, pre1, rdy1;
    logic row4, col4, wr4, rd4, pre4, rdy4;
    int checks = 0;
    int failures = 0;
    localparam logic [5:0] O_IDLE = 6'b000011;
    localparam logic [5:0] O_ROW  = 6'b100000;
    localparam logic [5:0] O_RD   = 6'b110100;
    localparam logic [5:0] O_WR   = 6'b111000;
    localparam logic [5:0] O_PRE  = 6'b000010;
    wire [5:0] o1 = {row1, col1, wr1, rd1, pre1, rdy1};
    wire [5:0] o4 = {row4, col4, wr4, rd4, pre4, rdy4};
    always #5 clk = ~clk;
    sram_control_fsm #(.ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .read_not_write(rnw1),
        .row_enable(row1), .col_enable(col1), .write_enable(wr1), .read_enable(rd1),
        .precharge_enable(pre1), .ready(rdy1)
    );
    sram_control_fsm #(.ACCESS_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .read_not_write(rnw4),
        .row_enable(row4), .col_enable(col4), .write_enable(wr4), .read_enable(rd4),
        .precharge_enable(pre4), .ready(rdy4)
    );
    task automatic step;
        @(negedge clk);
    endtask
    task automatic chk1(input string name, input logic [1:0] st, input logic [5:0] o);
        checks++;
        if (dut1.state !== st || o1 !== o) begin
            failures++;
            $display("FAIL %s: state=%b outs=%b expected state=%b outs=%b", name, dut1.state, o1, st, o);
        end
    endtask
    task automatic chk4(input string name, input logic [1:0] st, input logic [5:0] o);
        checks++;
        if (dut4.state !== st || o4 !== o) begin
            failures++;
            $display("FAIL %s: state=%b outs=%b expected state=%b outs=%b", name, dut4.state, o4, st, o);
        end
    endtask
    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        chk1("reset_n1", 2'b00, O_IDLE);
        chk4("reset_n4", 2'b00, O_IDLE);
        rst = 1'b0;
        step();
        chk1("idle_after_reset", 2'b00, O_IDLE);
    endtask
    task automatic test_read;
        en1 = 1'b1;
        rnw1 = 1'b1;
        #1;
        checks++;
        if (dut1.next_state !== 2'b01) begin
            failures++;
            $display("FAIL read_next_state: got %b expected 01", dut1.next_state);
        end
        step();
        en1 = 1'b0;
        chk1("read_row", 2'b01, O_ROW);
        step();
        chk1("read_access", 2'b10, O_RD);
        step();
        chk1("read_precharge", 2'b11, O_PRE);
        step();
        chk1("read_idle", 2'b00, O_IDLE);
    endtask
    task automatic test_write;
        en1 = 1'b1;
        rnw1 = 1'b0;
        step();
        en1 = 1'b0;
        chk1("write_row", 2'b01, O_ROW);
        step();
        chk1("write_access", 2'b10, O_WR);
        rnw1 = 1'b1;
        step();
        chk1("write_precharge", 2'b11, O_PRE);
        step();
        chk1("write_idle", 2'b00, O_IDLE);
    endtask
    task automatic test_busy_ignore;
        en1 = 1'b1;
        rnw1 = 1'b1;
        step();
        chk1("busy_row", 2'b01, O_ROW);
        rnw1 = 1'b0;
        step();
        chk1("busy_access_op_held", 2'b10, O_RD);
        en1 = 1'b0;
        step();
        chk1("busy_precharge", 2'b11, O_PRE);
        step();
        chk1("busy_idle", 2'b00, O_IDLE);
        step();
        chk1("busy_no_extra", 2'b00, O_IDLE);
    endtask
    task automatic test_back_to_back;
        logic [1:0] st_seq [4];
        logic [5:0] o_seq [4];
        st_seq = '{2'b01, 2'b10, 2'b11, 2'b00};
        o_seq = '{O_ROW, O_RD, O_PRE, O_IDLE};
        en1 = 1'b1;
        rnw1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk1($sformatf("b2b_cycle%0d", i), st_seq[i % 4], o_seq[i % 4]);
        end
        en1 = 1'b0;
        step();
        chk1("b2b_drain_pre", 2'b11, O_PRE);
        step();
        chk1("b2b_drain_idle", 2'b00, O_IDLE);
    endtask
    task automatic test_reset_mid_access;
        en4 = 1'b1;
        rnw4 = 1'b1;
        step();
        en4 = 1'b0;
        chk4("mid_row", 2'b01, O_ROW);
        step();
        chk4("mid_access1", 2'b10, O_RD);
        step();
        chk4("mid_access2", 2'b10, O_RD);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk4("mid_reset_idle", 2'b00, O_IDLE);
        checks++;
        if (dut4.op_rd !== 1'b1 || dut4.cnt !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset_regs: op_rd=%b cnt=%0d expected op_rd=1 cnt=0", dut4.op_rd, dut4.cnt);
        end
        en4 = 1'b1;
        rnw4 = 1'b0;
        step();
        en4 = 1'b0;
        chk4("n4_row", 2'b01, O_ROW);
        for (int i = 0; i < 4; i++) begin
            step();
            chk4($sformatf("n4_access%0d", i), 2'b10, O_WR);
        end
        step();
        chk4("n4_precharge", 2'b11, O_PRE);
        step();
        chk4("n4_idle", 2'b00, O_IDLE);
    endtask
    initial begin
        step();
        test_reset();
        test_read();
        test_write();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
